alu_issue_seq: RTL and testbench
================================

Name: alu_issue_seq

Overview:
- Upstream issue/sequencing stage for TotalALU.
- Accepts one operation at a time from the decoder through a valid/ready handshake and drives TotalALU's Signal/dataA/dataB.
- Holds multi-cycle MULTU/DIVU operands stable for the required count.
- Captures ALU results and presents them downstream through a valid/ready result port.

Parameters:
WIDTH, 32, operand/result width
MULDIV_CYCLES, 32, cycles alu_signal/operands are held for MULTU/DIVU before the sequencer returns to IDLE

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation offered by decoder
in_ready  out  1  sequencer can accept an operation
in_funct  in  6  operation code (ALU Signal encoding)
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
alu_signal  out  6  to TotalALU Signal
alu_dataA  out  WIDTH  to TotalALU dataA
alu_dataB  out  WIDTH  to TotalALU dataB
alu_result  in  WIDTH  from TotalALU Output
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_data  out  WIDTH  captured result
res_funct  out  6  funct that produced res_data
busy  out  1  MULTU/DIVU in progress
illegal  out  1  one-cycle pulse: unsupported funct accepted and dropped

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, sampled on the rising edge.
- Legal funct codes:
  - Single-cycle ops: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, SRL 2, MFHI 16, MFLO 18.
  - Multi-cycle ops: MULTU 25, DIVU 27.
- Reset values: state IDLE, in_ready 1, alu_signal 6'd32 (NOP=ADD), alu_dataA/alu_dataB 0, res_valid 0, res_data 0, res_funct 0, busy 0, illegal 0, wait counter 0.
- States: IDLE, EXEC, MDWAIT, RESULT.
- in_ready = (state==IDLE), combinational from state only. Accept = in_valid & in_ready at a rising edge.
- IDLE, on accept:
  - Legal single-cycle funct: register funct/a/b onto alu_signal/alu_dataA/alu_dataB; go to EXEC.
  - MULTU/DIVU: register them the same way; load counter with MULDIV_CYCLES-1; busy<=1; go to MDWAIT.
  - Illegal funct: illegal<=1 for exactly one cycle; ALU outputs untouched; stay IDLE.
- EXEC (exactly 1 cycle):
  - At the ending edge: res_data<=alu_result, res_funct<=alu_signal, res_valid<=1.
  - alu_signal<=32 and operands<=0 (NOP); go to RESULT.
  - Latency: accept at edge N -> res_valid high after edge N+1.
- MDWAIT:
  - alu_signal/alu_dataA/alu_dataB held constant; counter decrements each edge.
  - At the edge where counter==0: alu_signal<=32, operands<=0, busy<=0; go to IDLE.
  - Total cycles with alu_signal=25/27 = MULDIV_CYCLES. in_ready low throughout.
  - No res_valid; results are read later via MFHI/MFLO.
- RESULT:
  - res_valid, res_data and res_funct held stable until res_valid & res_ready at an edge.
  - On that handshake: res_valid<=0; go to IDLE. in_ready is 1 in the following cycle.
  - res_ready high on the first RESULT cycle completes the handshake in that cycle.
- alu_signal never shows 25 or 27 except during MDWAIT, so TotalALU never restarts spuriously.
- Reset in any state, including mid-MDWAIT or RESULT: all outputs return to reset values at that edge; the in-flight operation and any pending result are discarded.
- res_ready and in_valid are ignored in states where they have no effect; there is no pipelining or overlap.

Test Plan:
- ADD 5,7 accepted at edge N -> alu_signal=32, alu_dataA=5, alu_dataB=7 during cycle N; res_valid=1, res_data=12, res_funct=32 after edge N+1; res_ready=1 -> in_ready=1 next cycle.
- SUB 3,5 then SLT 0xFFFFFFFF,1 back-to-back -> res_data 0xFFFFFFFE, then 1; in_ready low in EXEC/RESULT of each.
- MULTU 100000,300000 -> alu_signal=25 for exactly 32 cycles, busy=1 and in_ready=0 throughout, no res_valid. Then MFHI -> res_data=6; MFLO -> res_data=4230196224.
- SLL op with res_ready held 0 for 3 cycles after res_valid -> res_data and res_funct stable, in_ready=0; completes on the first edge with res_ready=1.
- funct 5 offered in IDLE -> illegal=1 for one cycle, alu_signal stays 32, no res_valid, in_ready stays 1.
- Assert reset on the 10th MDWAIT cycle of DIVU -> next cycle state IDLE, busy=0, alu_signal=32, operands 0, in_ready=1.

Source files
------------

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue/sequencing stage that feeds TotalALU and returns its results.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : decoder handshake carrying in_funct, in_a, in_b
//   alu_signal/dataA/B: drive to TotalALU; alu_result is its output
//   res_valid/ready   : result handshake carrying res_data, res_funct
//   busy              : MULTU/DIVU operands are being held
//   illegal           : one-cycle pulse when an unsupported funct is dropped
module alu_issue_seq #(
    parameter int WIDTH = 32,
    parameter int MULDIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [5:0]       alu_signal,
    output logic [WIDTH-1:0] alu_dataA,
    output logic [WIDTH-1:0] alu_dataB,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [5:0]       res_funct,
    output logic             busy,
    output logic             illegal
);
    localparam int CW = MULDIV_CYCLES > 1 ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [5:0] NOP = 6'd32;
    typedef enum logic [1:0] {IDLE, EXEC, MDWAIT, RESULT} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic single, muldiv;
    assign in_ready = state == IDLE;
    always_comb begin
        single = in_funct inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0, 6'd2, 6'd16, 6'd18};
        muldiv = in_funct inside {6'd25, 6'd27};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            alu_signal <= NOP;
            alu_dataA  <= '0;
            alu_dataB  <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_funct  <= '0;
            busy       <= 1'b0;
            illegal    <= 1'b0;
            cnt        <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    if (single || muldiv) begin
                        alu_signal <= in_funct;
                        alu_dataA  <= in_a;
                        alu_dataB  <= in_b;
                        state      <= muldiv ? MDWAIT : EXEC;
                        busy       <= muldiv;
                        cnt        <= muldiv ? CW'(MULDIV_CYCLES - 1) : cnt;
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                EXEC: begin
                    res_data   <= alu_result;
                    res_funct  <= alu_signal;
                    res_valid  <= 1'b1;
                    alu_signal <= NOP;
                    alu_dataA  <= '0;
                    alu_dataB  <= '0;
                    state      <= RESULT;
                end
                // Operands stay put so TotalALU sees one uninterrupted MULTU/DIVU.
                MDWAIT: if (cnt == '0) begin
                    alu_signal <= NOP;
                    alu_dataA  <= '0;
                    alu_dataB  <= '0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESULT: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed scoreboard bench for alu_issue_seq with a behavioural TotalALU.
module tb_alu_issue_seq;
    localparam int W = 32;
    logic clk = 0, reset = 1, in_valid = 0, res_ready = 1;
    logic in_ready, res_valid, busy, illegal;
    logic [5:0] in_funct = 0, alu_signal, res_funct;
    logic [W-1:0] in_a = 0, in_b = 0, alu_dataA, alu_dataB, alu_result, res_data;
    logic [W-1:0] hi = 0, lo = 0;
    logic [37:0] sb[$];
    int checks = 0, errors = 0;

    alu_issue_seq #(.WIDTH(W), .MULDIV_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_a(in_a), .in_b(in_b), .alu_signal(alu_signal),
        .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_funct(res_funct), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Behavioural TotalALU: combinational ops, HI/LO written while MULTU/DIVU is presented.
    always_comb begin
        alu_result = '0;
        case (alu_signal)
            6'd32: alu_result = alu_dataA + alu_dataB;
            6'd34: alu_result = alu_dataA - alu_dataB;
            6'd36: alu_result = alu_dataA & alu_dataB;
            6'd37: alu_result = alu_dataA | alu_dataB;
            6'd42: alu_result = {31'd0, $signed(alu_dataA) < $signed(alu_dataB)};
            6'd0:  alu_result = alu_dataA << alu_dataB[4:0];
            6'd2:  alu_result = alu_dataA >> alu_dataB[4:0];
            6'd16: alu_result = hi;
            6'd18: alu_result = lo;
            default: alu_result = '0;
        endcase
    end
    always @(posedge clk) begin
        if (alu_signal == 6'd25) {hi, lo} <= 64'(alu_dataA) * 64'(alu_dataB);
        if (alu_signal == 6'd27 && alu_dataB != 0) begin
            hi <= alu_dataA % alu_dataB;
            lo <= alu_dataA / alu_dataB;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed at the edge where res_valid & res_ready.
    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got funct %0d data 0x%0h expected none", res_funct, res_data);
            end else begin
                logic [37:0] e;
                e = sb.pop_front();
                check("res_funct", {58'd0, res_funct}, {58'd0, e[37:32]});
                check("res_data", {32'd0, res_data}, {32'd0, e[31:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1");
        end
        in_valid = 1; in_funct = f; in_a = a; in_b = b;
        step();
        in_valid = 0;
    endtask

    initial begin
        int n25, bad;
        logic saw_valid;
        step(); step();
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_signal", alu_signal, 32);
        check("rst_operands", {alu_dataA, alu_dataB}, 0);
        check("rst_res", {res_valid, res_data, res_funct}, 0);
        check("rst_busy_illegal", {busy, illegal}, 0);
        reset = 0;
        step();
        // ADD 5,7
        sb.push_back({6'd32, 32'd12});
        issue(32, 5, 7);
        check("add_signal", alu_signal, 32);
        check("add_operands", {alu_dataA, alu_dataB}, {32'd5, 32'd7});
        check("add_in_ready_exec", in_ready, 0);
        step();
        check("add_res_valid", res_valid, 1);
        check("add_in_ready_result", in_ready, 0);
        step();
        check("add_in_ready_after", in_ready, 1);
        check("add_res_valid_after", res_valid, 0);
        // SUB then SLT back to back
        sb.push_back({6'd34, 32'hFFFF_FFFE});
        issue(34, 3, 5);
        check("sub_in_ready_exec", in_ready, 0);
        step();
        check("sub_in_ready_result", in_ready, 0);
        sb.push_back({6'd42, 32'd1});
        issue(42, 32'hFFFF_FFFF, 1);
        check("slt_in_ready_exec", in_ready, 0);
        step();
        check("slt_in_ready_result", in_ready, 0);
        step();
        // MULTU 100000 * 300000
        issue(25, 100000, 300000);
        n25 = 0; bad = 0; saw_valid = 0;
        for (int i = 0; i < 40; i++) begin
            if (alu_signal == 6'd25) begin
                n25++;
                if (!busy || in_ready) bad++;
            end
            if (res_valid) saw_valid = 1;
            step();
        end
        check("multu_cycles", n25, 32);
        check("multu_busy_ready", bad, 0);
        check("multu_no_res_valid", saw_valid, 0);
        check("multu_done", {busy, in_ready, alu_signal}, {1'b0, 1'b1, 6'd32});
        sb.push_back({6'd16, 32'd6});
        issue(16, 0, 0);
        step(); step();
        sb.push_back({6'd18, 32'd4230196224});
        issue(18, 0, 0);
        step(); step();
        // SLL with downstream stalled for 3 cycles
        res_ready = 0;
        sb.push_back({6'd0, 32'd48});
        issue(0, 3, 4);
        step();
        for (int i = 0; i < 3; i++) begin
            check("sll_hold_valid", res_valid, 1);
            check("sll_hold_data", {res_funct, res_data}, {6'd0, 32'd48});
            check("sll_hold_in_ready", in_ready, 0);
            step();
        end
        res_ready = 1;
        step();
        check("sll_done", {res_valid, in_ready}, 2'b01);
        // Illegal funct 5
        issue(5, 9, 9);
        check("ill_pulse", illegal, 1);
        check("ill_signal", alu_signal, 32);
        check("ill_in_ready", in_ready, 1);
        step();
        check("ill_clear", {illegal, res_valid, in_ready}, 3'b001);
        // Reset on the 10th DIVU cycle
        issue(27, 100, 7);
        for (int i = 0; i < 9; i++) step();
        check("divu_holding", {busy, alu_signal}, {1'b1, 6'd27});
        reset = 1;
        step();
        reset = 0;
        check("divu_rst_busy", busy, 0);
        check("divu_rst_signal", alu_signal, 32);
        check("divu_rst_operands", {alu_dataA, alu_dataB}, 0);
        check("divu_rst_in_ready", in_ready, 1);
        check("divu_rst_res_valid", res_valid, 0);
        sb.push_back({6'd32, 32'd3});
        issue(32, 1, 2);
        step(); step(); step();
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
